// File: rtl/unidad_riesgos.sv
// Hazard unit for the 5-stage RISC-V pipeline: forwarding, load-use stall, mispredict flush, MUL/DIV hold.
// Optional HAZARD_PERF_EN adds stall/flush performance counters.
module unidad_riesgos #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [4:0]  rs1d_i,
    input  logic [4:0]  rs2d_i,
    input  logic [4:0]  rs1e_i,
    input  logic [4:0]  rs2e_i,
    input  logic [4:0]  rde_i,
    input  logic [4:0]  rdm_i,
    input  logic [4:0]  rdw_i,
    input  logic        regwritem_i,
    input  logic        regwritew_i,
    input  logic        loade_i,
    input  logic        md_start_e_i,
    input  logic        mispredict_e_i,
    output logic        stall_f_o,
    output logic        stall_d_o,
    output logic        stall_e_o,
    output logic        flush_d_o,
    output logic        flush_e_o,
    output logic        flush_m_o,
    output logic [1:0]  forward_ae_o,
    output logic [1:0]  forward_be_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int unsigned CNT_W = $clog2(MD_LATENCY) + 1;
    localparam bit MdEn = (MD_LATENCY >= 2);
    localparam logic [CNT_W-1:0] MdLoad = MdEn ? CNT_W'(MD_LATENCY - 2) : '0;

    typedef enum logic {StRun, StMulti} state_e;

    state_e           r_state_q, r_state_d;
    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic             w_lwstall;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state_q <= StRun;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    assign w_lwstall = loade_i && (rde_i != 5'd0) && ((rde_i == rs1d_i) || (rde_i == rs2d_i));

    always_comb begin
        forward_ae_o = 2'b00;
        forward_be_o = 2'b00;
        if (reset_ni) begin
            // MEM is the younger producer, so it wins over WB.
            if (regwritem_i && (rdm_i != 5'd0) && (rdm_i == rs1e_i)) begin
                forward_ae_o = 2'b10;
            end else if (regwritew_i && (rdw_i != 5'd0) && (rdw_i == rs1e_i)) begin
                forward_ae_o = 2'b01;
            end
            if (regwritem_i && (rdm_i != 5'd0) && (rdm_i == rs2e_i)) begin
                forward_be_o = 2'b10;
            end else if (regwritew_i && (rdw_i != 5'd0) && (rdw_i == rs2e_i)) begin
                forward_be_o = 2'b01;
            end
        end
    end

    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_m_o = 1'b0;
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        if (reset_ni) begin
            unique case (r_state_q)
                StRun: begin
                    if (mispredict_e_i) begin
                        flush_d_o = 1'b1;
                        flush_e_o = 1'b1;
                    end else if (md_start_e_i && MdEn) begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        stall_e_o = 1'b1;
                        flush_m_o = 1'b1;
                        r_cnt_d   = MdLoad;
                        r_state_d = StMulti;
                    end else if (w_lwstall) begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        flush_e_o = 1'b1;
                    end
                end
                StMulti: begin
                    // Final cycle releases the op; held md_start must not re-arm it.
                    if (r_cnt_q != '0) begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        stall_e_o = 1'b1;
                        flush_m_o = 1'b1;
                        r_cnt_d   = r_cnt_q - 1'b1;
                    end else begin
                        r_state_d = StRun;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt_q;
    logic [31:0] r_flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_stall_cnt_q <= 32'd0;
            r_flush_cnt_q <= 32'd0;
        end else begin
            if (stall_f_o) r_stall_cnt_q <= r_stall_cnt_q + 32'd1;
            if (flush_d_o) r_flush_cnt_q <= r_flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt_q;
    assign flush_cnt_o = r_flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: doc/unidad_riesgos.md
Name: unidad_riesgos

Overview:
- Hazard controller for the 5-stage RISC-V pipeline.
- Generates stall/flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates forwarding selects for the EX operand muxes.
- Sequences multi-cycle EX operations (MUL/DIV) with a down-counter FSM, and resolves priority between load-use stalls, branch mispredict flushes and multi-cycle holds.

Parameters:
- MD_LATENCY, 4: total EX-stage cycles of a multi-cycle op; legal range 1..16. A value of 1 disables the multi-cycle hold.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  reset, synchronous, active-low.
- rs1d_i  in  5  rs1 of instruction in ID.
- rs2d_i  in  5  rs2 of instruction in ID.
- rs1e_i  in  5  rs1 of instruction in EX.
- rs2e_i  in  5  rs2 of instruction in EX.
- rde_i  in  5  rd of instruction in EX.
- rdm_i  in  5  rd of instruction in MEM.
- rdw_i  in  5  rd of instruction in WB.
- regwritem_i  in  1  MEM instruction writes the register file.
- regwritew_i  in  1  WB instruction writes the register file.
- loade_i  in  1  EX instruction is a load (result comes from memory).
- md_start_e_i  in  1  EX instruction is a multi-cycle op.
- mispredict_e_i  in  1  branch resolved in EX disagrees with the prediction.
- stall_f_o  out  1  hold the PC.
- stall_d_o  out  1  hold IF/ID.
- stall_e_o  out  1  hold ID/EX.
- flush_d_o  out  1  clear IF/ID.
- flush_e_o  out  1  clear ID/EX.
- flush_m_o  out  1  insert a bubble into EX/MEM.
- forward_ae_o  out  2  operand A select: 00 = regfile, 10 = MEM result, 01 = WB result.
- forward_be_o  out  2  operand B select, same encoding as forward_ae_o.
- stall_cnt_o  out  32  stall-cycle counter (see Optional Feature).
- flush_cnt_o  out  32  mispredict-flush counter (see Optional Feature).

Behaviour:
- Reset: while reset_ni=0 at a clock edge:
  - state <= RUN, cnt <= 0.
  - All control and forward outputs are forced to 0 combinationally while reset_ni=0.
- State and counter:
  - States: RUN and MULTI.
  - cnt is $clog2(MD_LATENCY)+1 bits wide.
  - Outputs are Mealy (state + inputs); there is no extra latency.
- Forwarding (pure combinational, every state):
  - forward_ae_o = 10 when regwritem_i & rdm_i!=0 & rdm_i==rs1e_i.
  - Else 01 when regwritew_i & rdw_i!=0 & rdw_i==rs1e_i.
  - Else 00.
  - MEM beats WB when both match.
  - forward_be_o follows the same rules using rs2e_i.
- Definition: lwstall = loade_i & rde_i!=0 & (rde_i==rs1d_i | rde_i==rs2d_i).
- RUN state, priority high to low:
  1. mispredict_e_i=1: flush_d_o=1, flush_e_o=1, all stalls 0. lwstall and md_start_e_i are ignored. Stay in RUN.
  2. md_start_e_i=1 and MD_LATENCY>=2:
     - stall_f_o=1, stall_d_o=1, stall_e_o=1, flush_m_o=1.
     - cnt <= MD_LATENCY-2; next state MULTI.
     - lwstall is ignored (ID is held anyway).
  3. lwstall=1: stall_f_o=1, stall_d_o=1, flush_e_o=1. Stay in RUN.
  4. Otherwise all controls are 0.
- MD_LATENCY=1: md_start_e_i is ignored and no hold is generated.
- MULTI state:
  - cnt!=0: stall_f_o, stall_d_o, stall_e_o and flush_m_o are all 1; cnt <= cnt-1.
  - cnt==0: all controls 0 (EX op completes and advances at this edge); next state RUN.
  - mispredict_e_i, md_start_e_i and lwstall are ignored in MULTI; EX holds the multi-cycle op.
- Net effect: a multi-cycle op produces exactly MD_LATENCY-1 consecutive stall cycles, and is never re-triggered by its own held md_start_e_i.
- flush_d_o and flush_e_o are never asserted together with stall_e_o.
- Reset asserted mid-MULTI: state returns to RUN on that edge and the hold is abandoned.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt_o increments on every clock edge where stall_f_o=1.
  - flush_cnt_o increments on every edge where flush_d_o=1.
  - Both are 32-bit, reset to 0 by reset_ni, and wrap 0xFFFFFFFF -> 0.
- Undefined: both ports remain present, tied to 0, and no counter registers are inferred.

Test Plan:
- Load-use: loade_i=1, rde_i=5, rs2d_i=5 for one cycle -> stall_f_o=stall_d_o=flush_e_o=1 that cycle only; stall_e_o=0; state stays RUN.
- Forwarding: regwritem_i=1, rdm_i=3, regwritew_i=1, rdw_i=3, rs1e_i=3, rs2e_i=0 -> forward_ae_o=10, forward_be_o=00. Then set regwritem_i=0 -> forward_ae_o=01.
- Multi-cycle, MD_LATENCY=4: md_start_e_i held high for 4 cycles from cycle 0 -> stall_f/d/e_o and flush_m_o =1 in cycles 0,1,2 and 0 in cycle 3. State is RUN at cycle 4. With HAZARD_PERF_EN, stall_cnt_o=3.
- Priority: mispredict_e_i=1 together with lwstall=1 and md_start_e_i=1 in RUN -> flush_d_o=flush_e_o=1, all stalls 0, no entry to MULTI. With HAZARD_PERF_EN, flush_cnt_o increments by 1.
- Ignore in MULTI: pulse mispredict_e_i=1 in cycle 1 of a 4-cycle hold -> flush_d_o=0, and the hold still ends in cycle 3.
- Reset mid-op: drive reset_ni=0 in cycle 1 of a hold -> all outputs 0 during reset. After release with md_start_e_i=0, controls stay 0 and counters read 0.
